// File: rtl/btn_pkg.sv
// Shared constants, types and helpers for the button conditioner.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat press pulses).
package btn_pkg;

  // Stability window defaults: short for simulation, ~8 ms at 125 MHz.
  localparam int STABLE_SIM = 3;
  localparam int STABLE_HW  = 1_000_000;

  // Per-channel hold state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  // Width of a counter that must reach the largest of the three limits.
  function automatic int cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF sync, stability debounce, edge and hold pulses.
// Ports:
//   clk, rst_p      clock, synchronous active-high reset
//   btn_raw         raw asynchronous button input (1 = pressed)
//   level           debounced level
//   press_pulse     1-cycle pulse on debounced rise (plus auto-repeat)
//   release_pulse   1-cycle pulse on debounced fall
//   long_pulse      1-cycle pulse once the level has been high LONG_CYCLES
// Macro BTN_AUTO_REPEAT_EN adds a repeat counter that re-fires press_pulse
// every REPEAT_CYCLES while the button stays held after long_pulse.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_SIM,
  parameter int LONG_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_p,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW =
    cnt_w(STABLE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);

  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] LONG_C   = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_M1  = CW'(LONG_CYCLES - 1);

  logic          s0;
  logic          s1;
  logic          cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hcnt;
  logic          level_prev;
  logic          long_hit;
  logic          rep_hit;
  logic          long_set;
  logic          rep_set;

  btn_state_t state;
  btn_state_t state_nxt;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= btn_raw;
      s1 <= s0;
    end
  end

  // Any change of the synchronised sample restarts the stability window;
  // the level only follows once the window has fully elapsed.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      cand  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else if (s1 != cand) begin
      cand <= s1;
      cnt  <= '0;
    end else if (cnt < STABLE_C) begin
      cnt <= cnt + 1'b1;
    end else begin
      level <= cand;
    end
  end

  // Hold counter saturates so the long-press hit is seen only once.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      hcnt <= '0;
    end else if (!level) begin
      hcnt <= '0;
    end else if (hcnt < LONG_C) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign long_hit = (hcnt == LONG_M1);

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_M1 = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] rcnt;

  // Starts from zero on the long-press edge, so the first repeat lands
  // REPEAT_CYCLES after the long_pulse cycle.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      rcnt <= '0;
    end else if (state != HELD || rep_hit) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign rep_hit = (rcnt == REP_M1);
`else
  assign rep_hit = 1'b0;
`endif

  // Hold FSM: state register.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Hold FSM: next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (level) begin
          state_nxt = long_hit ? HELD : PRESSED;
        end
      end
      PRESSED: begin
        if (!level) begin
          state_nxt = IDLE;
        end else if (long_hit) begin
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (!level) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold FSM: pulse requests, registered below with the edge pulses.
  always_comb begin
    long_set = 1'b0;
    rep_set  = 1'b0;
    unique case (state)
      IDLE, PRESSED: long_set = level && long_hit;
      HELD:          rep_set  = level && rep_hit;
      default: begin
        long_set = 1'b0;
        rep_set  = 1'b0;
      end
    endcase
  end

  // Registered edge detect and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      level_prev    <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      level_prev    <= level;
      press_pulse   <= (level & ~level_prev) | rep_set;
      release_pulse <= ~level & level_prev;
      long_pulse    <= long_set;
    end
  end

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner built from independent channels.
// Ports:
//   clk, rst_p      clock, synchronous active-high reset
//   btn_in          raw asynchronous button inputs, 1 = pressed
//   btn_level       debounced level per channel
//   press_pulse     1-cycle pulse per debounced press (plus auto-repeat)
//   release_pulse   1-cycle pulse per debounced release
//   long_pulse      1-cycle pulse after LONG_CYCLES of continuous hold
// Macro BTN_AUTO_REPEAT_EN enables auto-repeat press pulses per channel.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int STABLE_CYCLES = STABLE_SIM,
  parameter int LONG_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst_p         (rst_p),
      .btn_raw       (btn_in[i]),
      .level         (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi against a run-length model.
module tb_btn_debounce_multi;

  localparam int N    = 4;
  localparam int S    = 3;
  localparam int L    = 20;
  localparam int R    = 8;
  localparam int HOLD = 40;

  logic         clk = 1'b0;
  logic         rst_p = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_pulse;

  int n_chk  = 0;
  int n_pass = 0;

  btn_debounce_multi #(
    .N_BTN         (N),
    .STABLE_CYCLES (S),
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R)
  ) dut (
    .clk           (clk),
    .rst_p         (rst_p),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: a level follows the synchronised input once that
  // input has been seen unchanged for S+2 consecutive edges; pulses are
  // derived from how long the level has been high.
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_prev  = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel   = '0;
  logic [N-1:0] m_long  = '0;
  logic [N-1:0] d1      = '0;
  logic [N-1:0] d2      = '0;
  logic [N-1:0] run_val = '0;
  int run_len[N] = '{default: 1};
  int held[N]    = '{default: 0};

  always @(posedge clk) begin
    logic lo;
    logic po;
    logic sv;
    logic rep;
    for (int i = 0; i < N; i++) begin
      if (rst_p) begin
        d1[i] = 1'b0;
        d2[i] = 1'b0;
        run_val[i] = 1'b0;
        run_len[i] = 1;
        m_level[i] = 1'b0;
        m_prev[i] = 1'b0;
        held[i] = 0;
        m_press[i] = 1'b0;
        m_rel[i] = 1'b0;
        m_long[i] = 1'b0;
      end else begin
        lo = m_level[i];
        po = m_prev[i];
        held[i] = lo ? held[i] + 1 : 0;
`ifdef BTN_AUTO_REPEAT_EN
        rep = lo && held[i] > L && ((held[i] - L) % R == 0);
`else
        rep = 1'b0;
`endif
        m_press[i] = (lo & ~po) | rep;
        m_rel[i] = ~lo & po;
        m_long[i] = lo && held[i] == L;
        sv = d2[i];
        d2[i] = d1[i];
        d1[i] = btn_in[i];
        if (sv == run_val[i]) begin
          if (run_len[i] < 1000) run_len[i]++;
        end else begin
          run_val[i] = sv;
          run_len[i] = 1;
        end
        if (run_len[i] >= S + 2) m_level[i] = run_val[i];
        m_prev[i] = lo;
      end
    end
  end

  function automatic logic [4*N-1:0] exp_vec();
    return {m_level, m_press, m_rel, m_long};
  endfunction

  function automatic logic [4*N-1:0] dut_vec();
    return {btn_level, press_pulse, release_pulse, long_pulse};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_p = 1'b1;
    btn_in = '0;
    tick();
    tick();
    n_chk++;
    if (dut_vec() !== '0)
      $display("FAIL reset_state got=%h exp=0", dut_vec());
    else n_pass++;
    rst_p = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      n_chk++;
      if ((press_pulse | release_pulse | long_pulse | btn_level) !== '0)
        $display("FAIL idle_quiet k=%0d got=%h exp=0", k, dut_vec());
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    logic el;
    logic ep;
    logic er;
    btn_in[0] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (k == 9) btn_in[0] = 1'b0;
      el = (k >= S + 3) && (k < 10 + S + 3);
      ep = (k == S + 4);
      er = (k == 10 + S + 4);
      n_chk++;
      if (btn_level[0] !== el || press_pulse[0] !== ep ||
          release_pulse[0] !== er)
        $display("FAIL clean_press k=%0d got=%b%b%b exp=%b%b%b", k,
                 btn_level[0], press_pulse[0], release_pulse[0],
                 el, ep, er);
      else n_pass++;
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL model_clean k=%0d got=%h exp=%h", k,
                 dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int np;
    int pk;
    logic [3:0] pat;
    np = 0;
    pk = -1;
    pat = 4'b0101;
    btn_in[1] = pat[0];
    for (int k = 0; k < 4 + S + 12; k++) begin
      tick();
      btn_in[1] = (k + 1 < 4) ? pat[k+1] : 1'b1;
      if (press_pulse[1]) begin
        np++;
        pk = k;
      end
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL model_bounce k=%0d got=%h exp=%h", k,
                 dut_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (np !== 1 || pk !== 4 + S + 4)
      $display("FAIL bounce_press got=%0d@%0d exp=1@%0d", np, pk, 4 + S + 4);
    else n_pass++;
    btn_in[1] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL model_bounce_rel k=%0d got=%h exp=%h", k,
                 dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_long_press();
    int np;
    int nl;
    int nr;
    int lk;
    int rk;
    int rise;
    int exp_np;
    np = 0; nl = 0; nr = 0; lk = -1; rk = -1; rise = -1;
`ifdef BTN_AUTO_REPEAT_EN
    exp_np = 1 + (HOLD - L) / R;
`else
    exp_np = 1;
`endif
    btn_in[2] = 1'b1;
    for (int k = 0; k < HOLD + S + 15; k++) begin
      tick();
      if (k == HOLD - 1) btn_in[2] = 1'b0;
      if (btn_level[2] && rise < 0) rise = k;
      if (press_pulse[2]) np++;
      if (long_pulse[2]) begin nl++; lk = k; end
      if (release_pulse[2]) begin nr++; rk = k; end
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL model_long k=%0d got=%h exp=%h", k,
                 dut_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (rise !== S + 3)
      $display("FAIL long_rise got=%0d exp=%0d", rise, S + 3);
    else n_pass++;
    n_chk++;
    if (nl !== 1 || lk !== S + 3 + L)
      $display("FAIL long_pulse got=%0d@%0d exp=1@%0d", nl, lk, S + 3 + L);
    else n_pass++;
    n_chk++;
    if (nr !== 1 || rk !== HOLD + S + 4)
      $display("FAIL long_release got=%0d@%0d exp=1@%0d", nr, rk,
               HOLD + S + 4);
    else n_pass++;
    n_chk++;
    if (np !== exp_np)
      $display("FAIL long_press_count got=%0d exp=%0d", np, exp_np);
    else n_pass++;
  endtask

  task automatic test_simul_reset();
    int f0;
    int f3;
    btn_in = 4'b1001;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_chk++;
      if (press_pulse[0] !== press_pulse[3] ||
          press_pulse[0] !== (k == S + 4))
        $display("FAIL simul_press k=%0d got=%b%b exp=%b", k,
                 press_pulse[0], press_pulse[3], (k == S + 4));
      else n_pass++;
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL model_simul k=%0d got=%h exp=%h", k,
                 dut_vec(), exp_vec());
      else n_pass++;
    end
    rst_p = 1'b1;
    tick();
    n_chk++;
    if (dut_vec() !== '0)
      $display("FAIL mid_reset got=%h exp=0", dut_vec());
    else n_pass++;
    rst_p = 1'b0;
    f0 = -1;
    f3 = -1;
    for (int k = 0; k < S + 12; k++) begin
      tick();
      if (press_pulse[0] && f0 < 0) f0 = k;
      if (press_pulse[3] && f3 < 0) f3 = k;
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL model_post_rst k=%0d got=%h exp=%h", k,
                 dut_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (f0 !== S + 4 || f3 !== S + 4)
      $display("FAIL fresh_press got=%0d,%0d exp=%0d", f0, f3, S + 4);
    else n_pass++;
    btn_in = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL model_simul_rel k=%0d got=%h exp=%h", k,
                 dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int dur[N];
    for (int i = 0; i < N; i++) dur[i] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (dur[i] == 0) begin
          btn_in[i] = 1'($urandom_range(0, 1));
          dur[i] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(20, 45)) :
                   int'($urandom_range(1, 8));
        end
        dur[i]--;
      end
      rst_p = ($urandom_range(0, 399) == 0);
      tick();
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL model_random k=%0d got=%h exp=%h", k,
                 dut_vec(), exp_vec());
      else n_pass++;
      n_chk++;
      if ((press_pulse & release_pulse) !== '0)
        $display("FAIL press_release_overlap k=%0d got=%h exp=0", k,
                 press_pulse & release_pulse);
      else n_pass++;
    end
    rst_p = 1'b0;
    btn_in = '0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simul_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
